// File: rtl/wb_pkg.sv
// Shared types and defaults for the button-poll Wishbone initiator.
package wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READ  = 2'd2,
    ST_WRITE = 2'd3
  } poll_state_e;

  localparam logic [31:0] DEF_BTN_ADDR = 32'h3000_0000;
  localparam logic [31:0] DEF_LED_ADDR = 32'h3000_0004;
  localparam int unsigned DEF_BTN_BITS = 3;
  localparam int unsigned DEF_LED_W    = DEF_BTN_BITS + 1;

  // LED pattern carries an any-pressed bit above the raw button bits.
  function automatic int unsigned led_width(input int unsigned btn_bits);
    return btn_bits + 1;
  endfunction

endpackage

// File: rtl/wb_single_master.sv
// One Wishbone classic request: start -> cyc/stb held until ack or timeout.
module wb_single_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_c,
  output logic        timeout_c,
  output logic [31:0] rdata_c,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_addr_o,
  output logic [31:0] wb_data_o,
  input  logic        wb_ack_i,
  input  logic [31:0] wb_data_i
);

  localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic             cyc_q, cyc_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q  <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      tmo_q  <= '0;
    end else begin
      cyc_q  <= cyc_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      tmo_q  <= tmo_d;
    end
  end

  // Ack only counts while a cycle is open; the TIMEOUT-th silent cycle aborts.
  always_comb begin
    cyc_d     = cyc_q;
    we_d      = we_q;
    addr_d    = addr_q;
    data_d    = data_q;
    tmo_d     = tmo_q;
    done_c    = cyc_q & wb_ack_i;
    timeout_c = cyc_q & ~wb_ack_i & (tmo_q == TMO_W'(TIMEOUT - 1));
    if (!cyc_q) begin
      if (start_i) begin
        cyc_d  = 1'b1;
        we_d   = we_i;
        addr_d = addr_i;
        data_d = wdata_i;
        tmo_d  = '0;
      end
    end else if (done_c || timeout_c) begin
      cyc_d  = 1'b0;
      we_d   = 1'b0;
      addr_d = '0;
      data_d = '0;
      tmo_d  = '0;
    end else begin
      tmo_d = tmo_q + TMO_W'(1);
    end
  end

  assign busy_o    = cyc_q;
  assign rdata_c   = wb_data_i;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign wb_we_o   = we_q;
  assign wb_addr_o = addr_q;
  assign wb_data_o = data_q;

endmodule

// File: rtl/wb_button_poll_master.sv
// Polls the button register on an interval and mirrors changes to the LED register.
module wb_button_poll_master
  import wb_pkg::*;
#(
  parameter logic [31:0] BTN_ADDR    = DEF_BTN_ADDR,
  parameter logic [31:0] LED_ADDR    = DEF_LED_ADDR,
  parameter int unsigned BTN_BITS    = DEF_BTN_BITS,
  parameter int unsigned POLL_CYCLES = 1000,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  output logic                o_wb_cyc,
  output logic                o_wb_stb,
  output logic                o_wb_we,
  output logic [31:0]         o_wb_addr,
  output logic [31:0]         o_wb_data,
  input  logic                i_wb_ack,
  input  logic [31:0]         i_wb_data,
  output logic [BTN_BITS-1:0] o_buttons,
  output logic                o_event,
  output logic                o_err
);

  localparam int unsigned CNT_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int unsigned LED_W = led_width(BTN_BITS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(POLL_CYCLES - 1);

  poll_state_e         state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BTN_BITS-1:0] buttons_q, buttons_d;
  logic                first_q, first_d;
  logic                event_q, event_d;
  logic                err_q, err_d;

  logic                start_c;
  logic                req_we_c;
  logic [31:0]         req_addr_c;
  logic [31:0]         req_data_c;
  logic                busy;
  logic                done_c;
  logic                timeout_c;
  logic [31:0]         rdata_c;
  logic [BTN_BITS-1:0] btn_new_c;
  logic [LED_W-1:0]    led_pat_c;
  logic                unused_rdata_c;

  assign btn_new_c      = rdata_c[BTN_BITS-1:0];
  assign led_pat_c      = {|buttons_q, buttons_q};
  assign unused_rdata_c = ^rdata_c[31:BTN_BITS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      buttons_q <= '0;
      first_q   <= 1'b1;
      event_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      buttons_q <= buttons_d;
      first_q   <= first_d;
      event_q   <= event_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    buttons_d  = buttons_q;
    first_d    = first_q;
    event_d    = 1'b0;
    err_d      = err_q;
    start_c    = 1'b0;
    req_we_c   = 1'b0;
    req_addr_c = BTN_ADDR;
    req_data_c = '0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          cnt_d   = CNT_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_READ;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      // An open request always finishes before enable is honoured.
      ST_READ: begin
        start_c = ~busy;
        if (done_c) begin
          buttons_d = btn_new_c;
          cnt_d     = CNT_LOAD;
          if ((btn_new_c != buttons_q) || first_q) begin
            state_d = ST_WRITE;
          end else begin
            state_d = enable ? ST_WAIT : ST_IDLE;
          end
        end else if (timeout_c) begin
          err_d   = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = enable ? ST_WAIT : ST_IDLE;
        end
      end
      ST_WRITE: begin
        start_c    = ~busy;
        req_we_c   = 1'b1;
        req_addr_c = LED_ADDR;
        req_data_c = 32'(led_pat_c);
        if (done_c) begin
          event_d = 1'b1;
          first_d = 1'b0;
          cnt_d   = CNT_LOAD;
          state_d = enable ? ST_WAIT : ST_IDLE;
        end else if (timeout_c) begin
          err_d   = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = enable ? ST_WAIT : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  wb_single_master #(
    .TIMEOUT(TIMEOUT)
  ) u_master (
    .clk       (clk),
    .reset     (reset),
    .start_i   (start_c),
    .we_i      (req_we_c),
    .addr_i    (req_addr_c),
    .wdata_i   (req_data_c),
    .busy_o    (busy),
    .done_c    (done_c),
    .timeout_c (timeout_c),
    .rdata_c   (rdata_c),
    .wb_cyc_o  (o_wb_cyc),
    .wb_stb_o  (o_wb_stb),
    .wb_we_o   (o_wb_we),
    .wb_addr_o (o_wb_addr),
    .wb_data_o (o_wb_data),
    .wb_ack_i  (i_wb_ack),
    .wb_data_i (i_wb_data)
  );

  assign o_buttons = buttons_q;
  assign o_event   = event_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_wb_button_poll_master.sv
// Scoreboard bench: expected bus transactions queued with stimulus, popped as cycles close.
module tb_wb_button_poll_master;

  localparam logic [31:0] BTN_A = 32'h3000_0000;
  localparam logic [31:0] LED_A = 32'h3000_0004;
  localparam int unsigned TMO   = 8;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  len;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [31:0] o_wb_addr, o_wb_data;
  logic        i_wb_ack = 1'b0;
  logic [31:0] i_wb_data;
  logic [2:0]  o_buttons;
  logic        o_event, o_err;

  logic [2:0]  btn_val = 3'd0;
  int          ws = 0;
  logic        no_ack = 1'b0;

  txn_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          ev_count = 0;
  int          txn_count = 0;
  logic        in_txn = 1'b0;

  assign i_wb_data = 32'hA5A5_A5A0 | 32'(btn_val);

  always #5 clk = ~clk;

  wb_button_poll_master #(
    .POLL_CYCLES(4),
    .TIMEOUT(TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .o_wb_cyc  (o_wb_cyc),
    .o_wb_stb  (o_wb_stb),
    .o_wb_we   (o_wb_we),
    .o_wb_addr (o_wb_addr),
    .o_wb_data (o_wb_data),
    .i_wb_ack  (i_wb_ack),
    .i_wb_data (i_wb_data),
    .o_buttons (o_buttons),
    .o_event   (o_event),
    .o_err     (o_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic we, input logic [31:0] addr, input logic [31:0] data,
                          input int len);
    txn_t t;
    t.we   = we;
    t.addr = addr;
    t.data = data;
    t.len  = 8'(len);
    exp_q.push_back(t);
  endtask

  task automatic wait_empty(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || in_txn) && n < 300) begin
      @(posedge clk); #2;
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_cyc(input string tag, input logic want_we);
    int n = 0;
    logic seen = 1'b0;
    while (!seen && n < 200) begin
      @(posedge clk); #2;
      seen = o_wb_cyc && (o_wb_we == want_we);
      n++;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  // Bus monitor plus responder: sampled 1 time unit after each rising edge.
  initial begin
    logic        cur_we;
    logic [31:0] cur_addr, cur_data;
    int          len, ws_cnt;
    txn_t        e;
    cur_we = 1'b0; cur_addr = '0; cur_data = '0; len = 0; ws_cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (o_event) ev_count++;
      if (o_wb_cyc) begin
        check("stb_eq_cyc", 32'(o_wb_stb), 32'(o_wb_cyc));
        if (!in_txn) begin
          in_txn = 1'b1; len = 1; txn_count++;
          cur_we = o_wb_we; cur_addr = o_wb_addr; cur_data = o_wb_data;
        end else begin
          len++;
          check("hold_we", 32'(o_wb_we), 32'(cur_we));
          check("hold_addr", o_wb_addr, cur_addr);
          check("hold_data", o_wb_data, cur_data);
        end
      end else if (in_txn) begin
        in_txn = 1'b0;
        check("txn_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("txn_we", 32'(cur_we), 32'(e.we));
          check("txn_addr", cur_addr, e.addr);
          if (e.we) check("txn_data", cur_data, e.data);
          check("txn_len", 32'(len), 32'(e.len));
        end
      end
      if (!(o_wb_cyc && o_wb_stb)) begin
        i_wb_ack = 1'b0;
        ws_cnt   = 0;
      end else if (!no_ack && !i_wb_ack) begin
        if (ws_cnt >= ws) i_wb_ack = 1'b1;
        else ws_cnt++;
      end
    end
  end

  initial begin
    int tc;
    repeat (3) @(posedge clk);
    #2;
    check("rst_cyc", 32'(o_wb_cyc), 32'd0);
    check("rst_stb", 32'(o_wb_stb), 32'd0);
    check("rst_addr", o_wb_addr, 32'd0);
    check("rst_buttons", 32'(o_buttons), 32'd0);
    check("rst_event", 32'(o_event), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);

    // First poll always writes; repeat value only reads
    btn_val = 3'b101; ws = 0;
    push_exp(1'b0, BTN_A, 32'd0, 1);
    push_exp(1'b1, LED_A, 32'h0000_000D, 1);
    push_exp(1'b0, BTN_A, 32'd0, 1);
    reset = 1'b0;
    enable = 1'b1;
    wait_empty("p1_drain");
    check("p1_events", 32'(ev_count), 32'd1);
    check("p1_buttons", 32'(o_buttons), 32'd5);
    check("p1_err", 32'(o_err), 32'd0);

    // Value change to zero
    btn_val = 3'b000;
    push_exp(1'b0, BTN_A, 32'd0, 1);
    push_exp(1'b1, LED_A, 32'h0000_0000, 1);
    wait_empty("p2_drain");
    check("p2_events", 32'(ev_count), 32'd2);
    check("p2_buttons", 32'(o_buttons), 32'd0);

    // Three wait states
    ws = 3;
    push_exp(1'b0, BTN_A, 32'd0, 4);
    wait_empty("p3_drain");
    check("p3_events", 32'(ev_count), 32'd2);

    // Timeout: no ack, no write, buttons untouched
    ws = 0; no_ack = 1'b1; btn_val = 3'b110;
    push_exp(1'b0, BTN_A, 32'd0, TMO);
    wait_empty("p4_drain");
    check("p4_err", 32'(o_err), 32'd1);
    check("p4_buttons", 32'(o_buttons), 32'd0);
    check("p4_events", 32'(ev_count), 32'd2);
    no_ack = 1'b0;
    push_exp(1'b0, BTN_A, 32'd0, 1);
    push_exp(1'b1, LED_A, 32'h0000_000E, 1);
    wait_empty("p4b_drain");
    check("p4b_err_sticky", 32'(o_err), 32'd1);
    check("p4b_buttons", 32'(o_buttons), 32'd6);
    check("p4b_events", 32'(ev_count), 32'd3);

    // Enable drop mid-read: read completes, then no more cycles
    ws = 1;
    push_exp(1'b0, BTN_A, 32'd0, 2);
    wait_cyc("p5_read_seen", 1'b0);
    enable = 1'b0;
    wait_empty("p5_drain");
    tc = txn_count;
    repeat (20) @(posedge clk);
    #2;
    check("p5_no_cyc", 32'(txn_count), 32'(tc));
    check("p5_cyc_low", 32'(o_wb_cyc), 32'd0);

    // Reset during write drops cyc/stb asynchronously
    ws = 3; btn_val = 3'b001;
    push_exp(1'b0, BTN_A, 32'd0, 4);
    push_exp(1'b1, LED_A, 32'h0000_0009, 1);
    enable = 1'b1;
    wait_cyc("p6_write_seen", 1'b1);
    #1 reset = 1'b1;
    #1;
    check("p6_rst_cyc", 32'(o_wb_cyc), 32'd0);
    check("p6_rst_stb", 32'(o_wb_stb), 32'd0);
    check("p6_rst_err", 32'(o_err), 32'd0);
    check("p6_rst_buttons", 32'(o_buttons), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    check("p6_queue", 32'(exp_q.size()), 32'd0);

    // Same (zero) value after reset still writes because of first_poll
    ws = 0; btn_val = 3'b000;
    push_exp(1'b0, BTN_A, 32'd0, 1);
    push_exp(1'b1, LED_A, 32'h0000_0000, 1);
    reset = 1'b0;
    wait_empty("p7_drain");
    check("p7_events", 32'(ev_count), 32'd4);
    check("p7_buttons", 32'(o_buttons), 32'd0);
    check("p7_err", 32'(o_err), 32'd0);
    enable = 1'b0;
    repeat (10) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
